// File: rtl/echo_dac_tx_pkg.sv
// echo_dac_tx_pkg -- shared constants and types for the echo I2S transmitter.
//   Width defaults, the I2S frame length, bit counter width and the
//   transmitter FSM state encoding.
//   lrck_for_bit() maps a bit slot within the frame to the word-select level.
package echo_dac_tx_pkg;

  localparam int SINGLE_DAC_WIDTH_DEF = 19;
  localparam int DAC_DATA_WIDTH_DEF   = 38;
  localparam int SINGLE_ADC_WIDTH_DEF = 16;
  localparam int BCLK_DIV_DEF         = 4;

  // One I2S frame: 16 left slots followed by 16 right slots.
  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // Word select is low for the left half of the frame, high for the right half.
  function automatic logic lrck_for_bit(input logic [BIT_CNT_W-1:0] bit_idx);
    return (bit_idx >= BIT_CNT_W'(FRAME_BITS / 2));
  endfunction

endpackage

// File: rtl/echo_dac_tx_if.sv
// echo_dac_tx_if -- sample handshake between the echo engine and the I2S
// transmitter.
//   Echo_Out  : stereo sample {left, right}, each channel signed
//   echo_Done : Echo_Out is valid this cycle
//   din_ready : transmitter can take a sample this cycle
// master = sample producer, slave = transmitter.
interface echo_dac_tx_if #(
  parameter int DAC_DATA_WIDTH = 38
);
  logic [DAC_DATA_WIDTH-1:0] Echo_Out;
  logic                      echo_Done;
  logic                      din_ready;

  modport master (output Echo_Out, output echo_Done, input din_ready);
  modport slave  (input Echo_Out, input echo_Done, output din_ready);
endinterface

// File: rtl/echo_dac_sat.sv
// echo_dac_sat -- reduces one signed channel from IN_W to OUT_W bits.
//   din_i  : IN_W-bit two's complement sample
//   dout_o : OUT_W-bit two's complement result
// Build option ECHO_DAC_SAT_EN:
//   defined   -> saturate to the OUT_W range (clip to max positive / min negative)
//   undefined -> arithmetic shift right by IN_W-OUT_W (keep the top OUT_W bits)
module echo_dac_sat #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o
);

`ifdef ECHO_DAC_SAT_EN
  // The value fits when every bit from the sign down to bit OUT_W-1 agrees.
  always_comb begin
    dout_o = din_i[OUT_W-1:0];
    if (din_i[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din_i[IN_W-1]}}) begin
      dout_o = din_i[OUT_W-1:0];
    end else if (din_i[IN_W-1]) begin
      dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Dropping the low bits is an arithmetic shift: the sign stays in the MSB.
  assign dout_o = din_i[IN_W-1 -: OUT_W];

  logic unused_low_s;
  assign unused_low_s = ^din_i[IN_W-OUT_W-1:0];
`endif

endmodule

// File: rtl/echo_dac_tx.sv
// echo_dac_tx -- I2S transmitter for the echo engine's stereo output.
//   clk         : system clock, all state on its rising edge
//   rst         : synchronous active-high reset (priority over ce)
//   ce          : clock enable, low freezes every register
//   smp         : sample handshake (echo_dac_tx_if.slave: Echo_Out, echo_Done, din_ready)
//   bclk        : I2S bit clock, half period = BCLK_DIV enabled clk cycles
//   lrck        : I2S word select, 0 = left, 1 = right
//   sdata       : I2S serial data, MSB first, one bclk behind lrck
//   frame_start : one-clk pulse whenever a frame is loaded into the shifter
//   underrun    : one-clk pulse when a frame loads with no fresh sample (replay)
// Build option ECHO_DAC_SAT_EN selects saturation instead of shifting in the
// per-channel conversion (see echo_dac_sat).
// 2*SINGLE_ADC_WIDTH must equal the 32-slot frame length.
module echo_dac_tx
  import echo_dac_tx_pkg::*;
#(
  parameter int SINGLE_DAC_WIDTH = SINGLE_DAC_WIDTH_DEF,
  parameter int DAC_DATA_WIDTH   = DAC_DATA_WIDTH_DEF,
  parameter int SINGLE_ADC_WIDTH = SINGLE_ADC_WIDTH_DEF,
  parameter int BCLK_DIV         = BCLK_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  echo_dac_tx_if.slave  smp,
  output logic          bclk,
  output logic          lrck,
  output logic          sdata,
  output logic          frame_start,
  output logic          underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [SINGLE_ADC_WIDTH-1:0] left_s;
  logic [SINGLE_ADC_WIDTH-1:0] right_s;
  logic [FRAME_BITS-1:0]       frame_s;
  logic                        din_ready_s;
  logic                        accept_s;
  logic                        bclk_tick_s;
  logic                        fall_s;
  logic                        boundary_s;
  logic                        load_new_s;
  logic [FRAME_BITS-1:0]       load_word_d;

  tx_state_e                   state_q;
  logic [FRAME_BITS-1:0]       hold_q;
  logic                        hold_valid_q;
  logic [FRAME_BITS-1:0]       shift_q;
  logic [DIV_W-1:0]            div_q;
  logic [BIT_CNT_W-1:0]        bit_q;
  logic                        bclk_q;
  logic                        lrck_q;
  logic                        sdata_q;
  logic                        frame_start_q;
  logic                        underrun_q;

  echo_dac_sat #(
    .IN_W  (SINGLE_DAC_WIDTH),
    .OUT_W (SINGLE_ADC_WIDTH)
  ) u_sat_left (
    .din_i  (smp.Echo_Out[DAC_DATA_WIDTH-1 -: SINGLE_DAC_WIDTH]),
    .dout_o (left_s)
  );

  echo_dac_sat #(
    .IN_W  (SINGLE_DAC_WIDTH),
    .OUT_W (SINGLE_ADC_WIDTH)
  ) u_sat_right (
    .din_i  (smp.Echo_Out[SINGLE_DAC_WIDTH-1:0]),
    .dout_o (right_s)
  );

  assign frame_s       = {left_s, right_s};
  assign din_ready_s   = ~hold_valid_q & ce & ~rst;
  assign accept_s      = smp.echo_Done & din_ready_s;
  assign smp.din_ready = din_ready_s;

  assign bclk        = bclk_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // Bit-clock timing strobes and the word to load at the next frame boundary.
  always_comb begin
    bclk_tick_s = 1'b0;
    load_new_s  = 1'b0;
    // The shifter rotates rather than shifts, so after 32 slots it holds the
    // original frame again: replaying on underrun needs no extra copy.
    load_word_d = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
    if ((state_q == ST_RUN) && (div_q == DIV_W'(BCLK_DIV - 1))) begin
      bclk_tick_s = 1'b1;
    end else begin
      bclk_tick_s = 1'b0;
    end
    if (hold_valid_q) begin
      load_word_d = hold_q;
      load_new_s  = 1'b1;
    end else if (accept_s) begin
      // Sample arriving exactly at the boundary skips the holding register.
      load_word_d = frame_s;
      load_new_s  = 1'b1;
    end else begin
      load_new_s  = 1'b0;
    end
  end

  assign fall_s     = bclk_tick_s & bclk_q;
  assign boundary_s = fall_s & (bit_q == BIT_CNT_W'(FRAME_BITS - 1));

  // Transmitter FSM, bit clock generation, serial shifter and holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_q        <= {FRAME_BITS{1'b0}};
      hold_valid_q  <= 1'b0;
      shift_q       <= {FRAME_BITS{1'b0}};
      div_q         <= {DIV_W{1'b0}};
      bit_q         <= {BIT_CNT_W{1'b0}};
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else if (ce) begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          div_q   <= {DIV_W{1'b0}};
          bit_q   <= {BIT_CNT_W{1'b0}};
          bclk_q  <= 1'b0;
          lrck_q  <= 1'b0;
          sdata_q <= 1'b0;
          if (accept_s) begin
            shift_q       <= frame_s;
            frame_start_q <= 1'b1;
            state_q       <= ST_RUN;
          end else begin
            state_q       <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bclk_tick_s) begin
            div_q  <= {DIV_W{1'b0}};
            bclk_q <= ~bclk_q;
          end else begin
            div_q  <= div_q + DIV_W'(1);
          end
          // Data and word select move only on bclk falling edges; the bit
          // leaving the shifter belongs to the previous slot (I2S delay).
          if (fall_s) begin
            sdata_q <= shift_q[FRAME_BITS-1];
            bit_q   <= bit_q + BIT_CNT_W'(1);
            lrck_q  <= lrck_for_bit(bit_q + BIT_CNT_W'(1));
            if (boundary_s) begin
              shift_q       <= load_word_d;
              frame_start_q <= 1'b1;
              underrun_q    <= ~load_new_s;
            end else begin
              shift_q       <= {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
            end
          end
          if (boundary_s) begin
            hold_valid_q <= 1'b0;
          end else if (accept_s) begin
            hold_q       <= frame_s;
            hold_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_echo_dac_tx.sv
// tb_echo_dac_tx -- directed self-checking bench for echo_dac_tx with
// BCLK_DIV=2 (frame = 128 clk). A monitor reassembles each transmitted frame
// from sdata sampled on bclk rising edges and checks lrck per slot; the main
// sequence walks through load, hold, bypass, underrun, ce stall and reset.
// Expected words follow the ECHO_DAC_SAT_EN build option.
module tb_echo_dac_tx;

  localparam int BD = 2;

  logic clk;
  logic rst;
  logic ce;
  logic bclk, lrck, sdata, frame_start, underrun;

  echo_dac_tx_if #(.DAC_DATA_WIDTH(38)) smp ();

  echo_dac_tx #(
    .SINGLE_DAC_WIDTH (19),
    .DAC_DATA_WIDTH   (38),
    .SINGLE_ADC_WIDTH (16),
    .BCLK_DIV         (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .smp         (smp),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [18:0] vl [4];
  logic [18:0] vr [4];
  logic [15:0] el [4];
  logic [15:0] er [4];

  // Monitor state
  int          rc       = 0;
  int          prev_cnt = 0;
  int          lr_err   = 0;
  int          fs_cnt   = 0;
  int          ur_cnt   = 0;
  logic        bclk_prev = 1'b0;
  logic [31:0] acc      = 32'h0000_0000;
  logic [31:0] cap_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int idx);
    smp.Echo_Out  = {vl[idx], vr[idx]};
    smp.echo_Done = 1'b1;
    tick();
    smp.echo_Done = 1'b0;
  endtask

  task automatic wait_fs(input string tag, input int exp_gap, input int t_from, output int t_at);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((frame_start !== 1'b1) && (k < 400));
    t_at = cyc;
    check_val({tag, "_gap"}, 32'(cyc - t_from), 32'(exp_gap));
  endtask

  // Frame reassembly: the slot-0 bit of a frame is the previous frame's last bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rc        = 0;
        prev_cnt  = 0;
        bclk_prev = 1'b0;
      end else begin
        if (frame_start === 1'b1) begin
          fs_cnt++;
          prev_cnt = rc;
          rc       = 0;
        end
        if (underrun === 1'b1) ur_cnt++;
        if ((bclk === 1'b1) && (bclk_prev === 1'b0)) begin
          if ((rc == 0) && (prev_cnt == 32)) cap_q.push_back({acc[30:0], sdata});
          acc = {acc[30:0], sdata};
          if (lrck !== ((rc >= 16) ? 1'b1 : 1'b0)) lr_err++;
          rc++;
        end
        bclk_prev = bclk;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7, fsb;
    int exp_idx [6];

    vl[0] = 19'h01238; vr[0] = 19'h7FFF8;
    vl[1] = 19'h3FFFF; vr[1] = 19'h40000;
    vl[2] = 19'h01234; vr[2] = 19'h00000;
    vl[3] = 19'h12345; vr[3] = 19'h6ABCD;
`ifdef ECHO_DAC_SAT_EN
    el[0] = 16'h1238; er[0] = 16'hFFF8;
    el[1] = 16'h7FFF; er[1] = 16'h8000;
    el[2] = 16'h1234; er[2] = 16'h0000;
    el[3] = 16'h7FFF; er[3] = 16'h8000;
`else
    el[0] = 16'h0247; er[0] = 16'hFFFF;
    el[1] = 16'h7FFF; er[1] = 16'h8000;
    el[2] = 16'h0246; er[2] = 16'h0000;
    el[3] = 16'h2468; er[3] = 16'hD579;
`endif
    exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2;
    exp_idx[3] = 2; exp_idx[4] = 3; exp_idx[5] = 2;

    rst           = 1'b1;
    ce            = 1'b1;
    smp.echo_Done = 1'b0;
    smp.Echo_Out  = 38'h0;
    tick();
    tick();
    check_val("rst_bclk", 32'(bclk), 32'd0);
    check_val("rst_lrck", 32'(lrck), 32'd0);
    check_val("rst_sdata", 32'(sdata), 32'd0);
    check_val("rst_fs", 32'(frame_start), 32'd0);
    check_val("rst_ur", 32'(underrun), 32'd0);
    check_val("rst_rdy", 32'(smp.din_ready), 32'd0);

    rst = 1'b0;
    tick();
    check_val("idle_rdy", 32'(smp.din_ready), 32'd1);
    repeat (5) tick();
    check_val("idle_bclk", 32'(bclk), 32'd0);
    check_val("idle_fs_cnt", 32'(fs_cnt), 32'd0);

    // IDLE load goes straight to the shifter; the next sample fills the hold.
    send(0);
    t0 = cyc;
    check_val("load_fs", 32'(frame_start), 32'd1);
    check_val("load_rdy", 32'(smp.din_ready), 32'd1);
    send(1);
    check_val("hold_rdy", 32'(smp.din_ready), 32'd0);

    wait_fs("v1", 128, t0, t1);
    check_val("v1_ur", 32'(underrun), 32'd0);
    check_val("v1_rdy", 32'(smp.din_ready), 32'd1);

    // Bypass: sample accepted in the boundary cycle with the hold empty.
    while (cyc - t1 < 127) tick();
    check_val("byp_rdy_pre", 32'(smp.din_ready), 32'd1);
    smp.Echo_Out  = {vl[2], vr[2]};
    smp.echo_Done = 1'b1;
    tick();
    smp.echo_Done = 1'b0;
    t2 = cyc;
    check_val("byp_gap", 32'(t2 - t1), 32'd128);
    check_val("byp_fs", 32'(frame_start), 32'd1);
    check_val("byp_ur", 32'(underrun), 32'd0);
    check_val("byp_rdy", 32'(smp.din_ready), 32'd1);

    // Nothing held -> replay with underrun.
    wait_fs("rep", 128, t2, t3);
    check_val("rep_ur", 32'(underrun), 32'd1);
    tick();
    check_val("rep_ur_end", 32'(underrun), 32'd0);

    send(3);
    wait_fs("v3", 128, t3, t4);
    check_val("v3_ur", 32'(underrun), 32'd0);

    // ce stall of 7 cycles at slot 26 while bclk is high; a sample offered
    // during the stall must be ignored.
    while (cyc - t4 < 106) tick();
    ce            = 1'b0;
    smp.Echo_Out  = {vl[0], vr[0]};
    smp.echo_Done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("stall_bclk", 32'(bclk), 32'd1);
      check_val("stall_lrck", 32'(lrck), 32'd1);
      check_val("stall_rdy", 32'(smp.din_ready), 32'd0);
      check_val("stall_fs", 32'(frame_start), 32'd0);
    end
    ce            = 1'b1;
    smp.echo_Done = 1'b0;
    wait_fs("stall", 135, t4, t5);
    check_val("stall_ur", 32'(underrun), 32'd1);

    // Reset at slot 10 with a sample waiting in the hold.
    send(1);
    check_val("pre_rst_rdy", 32'(smp.din_ready), 32'd0);
    while (cyc - t5 < 40) tick();
    rst = 1'b1;
    tick();
    check_val("mr_bclk", 32'(bclk), 32'd0);
    check_val("mr_lrck", 32'(lrck), 32'd0);
    check_val("mr_sdata", 32'(sdata), 32'd0);
    check_val("mr_fs", 32'(frame_start), 32'd0);
    check_val("mr_ur", 32'(underrun), 32'd0);
    check_val("mr_rdy", 32'(smp.din_ready), 32'd0);
    tick();
    rst = 1'b0;
    fsb = fs_cnt;
    repeat (20) tick();
    check_val("post_rst_bclk", 32'(bclk), 32'd0);
    check_val("post_rst_fs", 32'(fs_cnt - fsb), 32'd0);
    check_val("post_rst_rdy", 32'(smp.din_ready), 32'd1);

    send(2);
    t6 = cyc;
    check_val("rs_fs", 32'(frame_start), 32'd1);
    wait_fs("rs_rep", 128, t6, t7);
    check_val("rs_ur", 32'(underrun), 32'd1);
    repeat (4) tick();

    check_val("cap_count", 32'(cap_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("frame%0d", i),
                (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF,
                {el[exp_idx[i]], er[exp_idx[i]]});
    end
    check_val("lrck_slots", 32'(lr_err), 32'd0);
    check_val("ur_total", 32'(ur_cnt), 32'd3);
    check_val("fs_total", 32'(fs_cnt), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
